serdes_link_sched: RTL and testbench

//  Round-robin scheduler sharing one 40-bit serializer/deserializer link among NUM_REQ requesters.

---
 rtl/serdes_link_sched.sv | 118 +++++++++++
 tb/tb_serdes_link_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_link_sched.sv
// Round-robin scheduler that shares one serializer/deserializer link among NUM_REQ requesters.
// Optional finish-wait timeout: define SERDES_SCHED_TIMEOUT_EN.
module serdes_link_sched #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 40,
  parameter int FRAME_LEN = 40,
  parameter int GAP_CYC   = 2,
  parameter int TO_CYC    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]          ser_data,
  output logic                       ser_data_rdy,
  input  logic                       des_finish,
  output logic                       busy,
  output logic [5:0]                 bit_cnt,
  output logic                       done_valid,
  output logic [$clog2(NUM_REQ)-1:0] done_id,
  output logic                       timeout_err,
  output logic [1:0]                 state_dbg
);

  localparam int IW = $clog2(NUM_REQ);

  // Handshake: a word transfers on a clock edge where req_valid[i] & req_ready[i];
  // req_ready is a one-hot grant, only ever non-zero in IDLE.
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_FIN, GAP} state_t;

  state_t        state, state_nx, post_st;
  logic [IW-1:0] last_grant, grant_idx;
  logic          grant_vld, accept, fin_ok, to_hit, gap_done, last_bit;
  logic [7:0]    gap_cnt;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!grant_vld && req_valid[IW'((int'(last_grant) + i) % NUM_REQ)]) begin
        grant_vld = 1'b1;
        grant_idx = IW'((int'(last_grant) + i) % NUM_REQ);
      end
    end
  end

  assign accept    = (state == IDLE) && grant_vld;
  assign req_ready = (accept && rst) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign last_bit  = (bit_cnt == 6'(FRAME_LEN - 1));
  // Finish pulses before the final shift cycle belong to no frame and are dropped.
  assign fin_ok    = des_finish && (((state == SHIFT) && last_bit) || (state == WAIT_FIN));
  assign gap_done  = (gap_cnt == 8'(GAP_CYC - 1));
  assign post_st   = (GAP_CYC == 0) ? IDLE : GAP;
  assign busy      = (state != IDLE);
  assign done_valid  = fin_ok;
  assign timeout_err = to_hit;
  assign state_dbg   = state;

`ifdef SERDES_SCHED_TIMEOUT_EN
  logic [3:0] wait_cnt;

  // Completion beats timeout when both land in the same cycle.
  assign to_hit = (state == WAIT_FIN) && (wait_cnt == 4'(TO_CYC)) && !des_finish;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   wait_cnt <= '0;
    else if (state == WAIT_FIN) wait_cnt <= wait_cnt + 4'd1;
    else                        wait_cnt <= '0;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (accept) state_nx = SHIFT;
      SHIFT: begin
        if (fin_ok)        state_nx = post_st;
        else if (last_bit) state_nx = WAIT_FIN;
      end
      WAIT_FIN: if (fin_ok || to_hit) state_nx = post_st;
      GAP:      if (gap_done) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ser_data     <= '0;
      ser_data_rdy <= 1'b0;
      done_id      <= '0;
      last_grant   <= IW'(NUM_REQ - 1);
      bit_cnt      <= '0;
      gap_cnt      <= '0;
    end else begin
      ser_data_rdy <= 1'b0;
      if (accept) begin
        ser_data     <= req_data[grant_idx*DATA_W +: DATA_W];
        ser_data_rdy <= 1'b1;
        done_id      <= grant_idx;
        last_grant   <= grant_idx;
        bit_cnt      <= '0;
      end else if ((state == SHIFT) && !last_bit) begin
        bit_cnt <= bit_cnt + 6'd1;
      end
      if (state == GAP) gap_cnt <= gap_cnt + 8'd1;
      else              gap_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_serdes_link_sched.sv
// Directed bench for serdes_link_sched: reset, single frame, round robin, early finish,
// finish wait / timeout (SERDES_SCHED_TIMEOUT_EN) and reset during a shift.
module tb_serdes_link_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [159:0] req_data;
  logic [3:0]   req_ready;
  logic [39:0]  ser_data;
  logic         ser_data_rdy;
  logic         des_finish;
  logic         busy;
  logic [5:0]   bit_cnt;
  logic         done_valid;
  logic [1:0]   done_id;
  logic         timeout_err;
  logic [1:0]   state_dbg;

  int pass_cnt = 0;
  int check_cnt = 0;
  logic [39:0] lane_w [4];

  serdes_link_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .ser_data(ser_data), .ser_data_rdy(ser_data_rdy),
    .des_finish(des_finish), .busy(busy), .bit_cnt(bit_cnt),
    .done_valid(done_valid), .done_id(done_id), .timeout_err(timeout_err),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled just after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Runs an accepted frame to its earliest completion and through the gap; ends in IDLE.
  task automatic run_frame(input logic [3:0] hold_valid);
    for (int c = 1; c <= 42; c++) begin
      step();
      if (c == 1) req_valid = hold_valid;
      des_finish = (c == 40);
    end
    step();
    des_finish = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 4'b1111;
    des_finish = 1'b0;
    step();
    #1;
    check_cnt++;
    if ({req_ready, busy, ser_data_rdy, bit_cnt, done_valid, done_id, timeout_err, state_dbg} !== '0)
      $display("FAIL reset_outs: got %b required 0",
        {req_ready, busy, ser_data_rdy, bit_cnt, done_valid, done_id, timeout_err, state_dbg});
    else pass_cnt++;
    check_cnt++;
    if (ser_data !== 40'h0) $display("FAIL reset_data: got %h required 0", ser_data);
    else pass_cnt++;
    req_valid = 4'b0000;
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    req_valid = 4'b0001;
    #1;
    check_cnt++;
    if (req_ready !== 4'b0001) $display("FAIL t1_ready: got %b required 0001", req_ready);
    else pass_cnt++;
    step();
    req_valid = 4'b0000;
    #1;
    check_cnt++;
    if ({ser_data_rdy, ser_data, done_id, bit_cnt, state_dbg} !== {1'b1, 40'hA5_5A5A_A55A, 2'd0, 6'd0, 2'd1})
      $display("FAIL t1_load: got rdy=%b data=%h id=%0d cnt=%0d st=%0d", ser_data_rdy, ser_data, done_id, bit_cnt, state_dbg);
    else pass_cnt++;
    step();
    check_cnt++;
    if ({ser_data_rdy, bit_cnt} !== {1'b0, 6'd1})
      $display("FAIL t1_strobe_once: got rdy=%b cnt=%0d required rdy=0 cnt=1", ser_data_rdy, bit_cnt);
    else pass_cnt++;
    repeat (38) step();
    des_finish = 1'b1;
    #1;
    check_cnt++;
    if ({bit_cnt, done_valid, done_id} !== {6'd39, 1'b1, 2'd0})
      $display("FAIL t1_done: got cnt=%0d dv=%b id=%0d required 39/1/0", bit_cnt, done_valid, done_id);
    else pass_cnt++;
    step();
    des_finish = 1'b0;
    req_valid = 4'b0010;
    #1;
    check_cnt++;
    if ({state_dbg, busy, done_valid, req_ready} !== {2'd3, 1'b1, 1'b0, 4'b0000})
      $display("FAIL t1_gap: got st=%0d busy=%b dv=%b rdy=%b", state_dbg, busy, done_valid, req_ready);
    else pass_cnt++;
    step();
    step();
    check_cnt++;
    if ({req_ready, busy} !== {4'b0010, 1'b0})
      $display("FAIL t1_idle: got rdy=%b busy=%b required 0010/0", req_ready, busy);
    else pass_cnt++;
    req_valid = 4'b0000;
    step();
    check_cnt++;
    if (state_dbg !== 2'd0) $display("FAIL t1_drop_valid: got st=%0d required 0", state_dbg);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    rst = 1'b0;
    step();
    rst = 1'b1;
    req_valid = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      exp_g = 2'(f % 4);
      #1;
      check_cnt++;
      if ({req_ready, busy} !== {4'(1 << exp_g), 1'b0})
        $display("FAIL rr_grant%0d: got rdy=%b busy=%b required %b/0", f, req_ready, busy, 4'(1 << exp_g));
      else pass_cnt++;
      for (int c = 1; c <= 42; c++) begin
        step();
        des_finish = (c == 40);
        #1;
        check_cnt++;
        if ({busy, req_ready, done_valid} !== {1'b1, 4'b0000, (c == 40)})
          $display("FAIL rr_busy%0d_%0d: got busy=%b rdy=%b dv=%b", f, c, busy, req_ready, done_valid);
        else pass_cnt++;
        if (c == 1 || c == 40) begin
          check_cnt++;
          if ({ser_data, done_id} !== {lane_w[exp_g], exp_g})
            $display("FAIL rr_data%0d_%0d: got %h id=%0d required %h id=%0d", f, c, ser_data, done_id, lane_w[exp_g], exp_g);
          else pass_cnt++;
        end
      end
      step();
      des_finish = 1'b0;
    end
    req_valid = 4'b0000;
    step();
  endtask

  task automatic test_rr_priority();
    req_valid = 4'b0100;
    #1;
    check_cnt++;
    if (req_ready !== 4'b0100) $display("FAIL p_setup: got %b required 0100", req_ready);
    else pass_cnt++;
    run_frame(4'b1100);
    #1;
    check_cnt++;
    if (req_ready !== 4'b1000) $display("FAIL p_first: got %b required 1000", req_ready);
    else pass_cnt++;
    run_frame(4'b1100);
    #1;
    check_cnt++;
    if (req_ready !== 4'b0100) $display("FAIL p_second: got %b required 0100", req_ready);
    else pass_cnt++;
    run_frame(4'b0000);
  endtask

  task automatic test_early_finish();
    req_valid = 4'b0010;
    #1;
    check_cnt++;
    if (req_ready !== 4'b0010) $display("FAIL e_ready: got %b required 0010", req_ready);
    else pass_cnt++;
    for (int c = 1; c <= 44; c++) begin
      step();
      req_valid = 4'b0000;
      des_finish = (c == 11 || c == 44);
      #1;
      check_cnt++;
      if (done_valid !== (c == 44)) $display("FAIL e_done_%0d: got %b required %b", c, done_valid, (c == 44));
      else pass_cnt++;
      if (c == 11 || c == 41) begin
        check_cnt++;
        if ({state_dbg, bit_cnt} !== ((c == 11) ? {2'd1, 6'd10} : {2'd2, 6'd39}))
          $display("FAIL e_state_%0d: got st=%0d cnt=%0d", c, state_dbg, bit_cnt);
        else pass_cnt++;
      end
    end
    check_cnt++;
    if (done_id !== 2'd1) $display("FAIL e_id: got %0d required 1", done_id);
    else pass_cnt++;
    step();
    des_finish = 1'b0;
    step();
    step();
    check_cnt++;
    if (state_dbg !== 2'd0) $display("FAIL e_idle: got st=%0d required 0", state_dbg);
    else pass_cnt++;
  endtask

  task automatic test_no_finish();
    req_valid = 4'b0001;
    #1;
    check_cnt++;
    if (req_ready !== 4'b0001) $display("FAIL n_ready: got %b required 0001", req_ready);
    else pass_cnt++;
`ifdef SERDES_SCHED_TIMEOUT_EN
    for (int c = 1; c <= 52; c++) begin
      step();
      req_valid = 4'b0000;
      #1;
      if (c >= 41) begin
        check_cnt++;
        if ({timeout_err, done_valid, state_dbg} !== {(c == 49), 1'b0, (c <= 49) ? 2'd2 : (c <= 51) ? 2'd3 : 2'd0})
          $display("FAIL n_timeout_%0d: got to=%b dv=%b st=%0d", c, timeout_err, done_valid, state_dbg);
        else pass_cnt++;
      end
    end
    check_cnt++;
    if (done_id !== 2'd0) $display("FAIL n_id: got %0d required 0", done_id);
    else pass_cnt++;
`else
    for (int c = 1; c <= 60; c++) begin
      step();
      req_valid = 4'b0000;
      #1;
      if (c >= 41) begin
        check_cnt++;
        if ({timeout_err, done_valid, state_dbg, busy} !== {1'b0, 1'b0, 2'd2, 1'b1})
          $display("FAIL n_wait_%0d: got to=%b dv=%b st=%0d busy=%b", c, timeout_err, done_valid, state_dbg, busy);
        else pass_cnt++;
      end
    end
    step();
    des_finish = 1'b1;
    #1;
    check_cnt++;
    if ({done_valid, done_id} !== {1'b1, 2'd0}) $display("FAIL n_late_done: got dv=%b id=%0d required 1/0", done_valid, done_id);
    else pass_cnt++;
    step();
    des_finish = 1'b0;
    step();
    step();
`endif
    check_cnt++;
    if (state_dbg !== 2'd0) $display("FAIL n_idle: got st=%0d required 0", state_dbg);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b1111;
    #1;
    check_cnt++;
    if (req_ready !== 4'b0010) $display("FAIL r_ready: got %b required 0010", req_ready);
    else pass_cnt++;
    repeat (21) step();
    check_cnt++;
    if ({state_dbg, bit_cnt} !== {2'd1, 6'd20}) $display("FAIL r_pos: got st=%0d cnt=%0d required 1/20", state_dbg, bit_cnt);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    check_cnt++;
    if ({req_ready, busy, ser_data_rdy, bit_cnt, done_valid, done_id, timeout_err, state_dbg, ser_data} !== '0)
      $display("FAIL r_clear: got rdy=%b busy=%b cnt=%0d id=%0d data=%h", req_ready, busy, bit_cnt, done_id, ser_data);
    else pass_cnt++;
    step();
    rst = 1'b1;
    #1;
    check_cnt++;
    if (req_ready !== 4'b0001) $display("FAIL r_prio: got %b required 0001", req_ready);
    else pass_cnt++;
    req_valid = 4'b0000;
    step();
  endtask

  initial begin
    lane_w[0] = 40'hA5_5A5A_A55A;
    lane_w[1] = 40'h11_2233_4455;
    lane_w[2] = 40'hC3_C3C3_3C3C;
    lane_w[3] = 40'hFE_DCBA_9876;
    for (int i = 0; i < 4; i++) req_data[i*40 +: 40] = lane_w[i];
    test_reset();
    test_single();
    test_round_robin();
    test_rr_priority();
    test_early_finish();
    test_no_finish();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
